// File: rtl/riscv_reg_file_if.sv
// Register-file access bus: decode supplies read addresses, writeback supplies
// the write port, and the file returns both operands combinationally.
`timescale 1ns/1ps
interface riscv_reg_file_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] ADD_A;
    logic [ADDR_W-1:0] ADD_B;
    logic [ADDR_W-1:0] ADD_D;
    logic [DATA_W-1:0] REG_D;
    logic              WE;
    logic [DATA_W-1:0] REG_A;
    logic [DATA_W-1:0] REG_B;

    modport master (
        output ADD_A, ADD_B, ADD_D, REG_D, WE,
        input  REG_A, REG_B
    );

    modport slave (
        input  ADD_A, ADD_B, ADD_D, REG_D, WE,
        output REG_A, REG_B
    );
endinterface

// File: rtl/riscv_reg_file.sv
// 32-entry RISC-V integer register file: two combinational read ports, one
// synchronous write port, x0 hardwired to zero, optional write-to-read bypass.
`timescale 1ns/1ps
module riscv_reg_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter bit BYPASS = 1'b1
) (
    input  logic              CLK,
    input  logic              RST_N,
    riscv_reg_file_if.slave   bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_r [DEPTH];
    logic [DATA_W-1:0] rd_a_s;
    logic [DATA_W-1:0] rd_b_s;
    logic              wr_en_s;

    // Entry 0 is never written, so it stays at its reset value of zero.
    assign wr_en_s = bus.WE && (bus.ADD_D != {ADDR_W{1'b0}});

    // Register storage with asynchronous clear.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else if (wr_en_s) begin
            regs_r[bus.ADD_D] <= bus.REG_D;
        end else begin
            regs_r[bus.ADD_D] <= regs_r[bus.ADD_D];
        end
    end

    // Port A read: reset and x0 dominate the bypass path.
    always_comb begin
        rd_a_s = {DATA_W{1'b0}};
        if (!RST_N || (bus.ADD_A == {ADDR_W{1'b0}})) begin
            rd_a_s = {DATA_W{1'b0}};
        end else if (BYPASS && wr_en_s && (bus.ADD_A == bus.ADD_D)) begin
            rd_a_s = bus.REG_D;
        end else begin
            rd_a_s = regs_r[bus.ADD_A];
        end
    end

    // Port B read: same rules as port A.
    always_comb begin
        rd_b_s = {DATA_W{1'b0}};
        if (!RST_N || (bus.ADD_B == {ADDR_W{1'b0}})) begin
            rd_b_s = {DATA_W{1'b0}};
        end else if (BYPASS && wr_en_s && (bus.ADD_B == bus.ADD_D)) begin
            rd_b_s = bus.REG_D;
        end else begin
            rd_b_s = regs_r[bus.ADD_B];
        end
    end

    assign bus.REG_A = rd_a_s;
    assign bus.REG_B = rd_b_s;
endmodule

// File: tb/tb_riscv_reg_file.sv
// Self-checking bench: drives a bypassing and a non-bypassing instance in lockstep
// and compares both read ports against a table and an array-based reference model.
`timescale 1ns/1ps
module tb_riscv_reg_file;
    logic        CLK;
    logic        rst_n;
    logic        we;
    logic [4:0]  add_a, add_b, add_d;
    logic [31:0] wd;

    int n_pass = 0;
    int n_total = 0;
    logic [31:0] mem [32];

    riscv_reg_file_if #(.DATA_W(32), .ADDR_W(5)) bus1 ();
    riscv_reg_file_if #(.DATA_W(32), .ADDR_W(5)) bus0 ();

    assign bus1.ADD_A = add_a;  assign bus0.ADD_A = add_a;
    assign bus1.ADD_B = add_b;  assign bus0.ADD_B = add_b;
    assign bus1.ADD_D = add_d;  assign bus0.ADD_D = add_d;
    assign bus1.REG_D = wd;     assign bus0.REG_D = wd;
    assign bus1.WE    = we;     assign bus0.WE    = we;

    riscv_reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) dut_byp (
        .CLK(CLK), .RST_N(rst_n), .bus(bus1)
    );
    riscv_reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0)) dut_nobyp (
        .CLK(CLK), .RST_N(rst_n), .bus(bus0)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        we;
        logic [4:0]  ad;
        logic [4:0]  aa;
        logic [4:0]  ab;
        logic [31:0] wd;
        logic [31:0] ea1;
        logic [31:0] eb1;
        logic [31:0] ea0;
        logic [31:0] eb0;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // Expected read value straight from the architectural rules.
    function automatic logic [31:0] model_read(input logic [4:0] a, input bit byp);
        if (!rst_n || a == 5'd0) return 32'h0;
        if (byp && we && add_d != 5'd0 && add_d == a) return wd;
        return mem[a];
    endfunction

    task automatic check_model(input string tag);
        check({tag, "_a_byp"},   bus1.REG_A, model_read(add_a, 1'b1));
        check({tag, "_b_byp"},   bus1.REG_B, model_read(add_b, 1'b1));
        check({tag, "_a_nobyp"}, bus0.REG_A, model_read(add_a, 1'b0));
        check({tag, "_b_nobyp"}, bus0.REG_B, model_read(add_b, 1'b0));
    endtask

    // One clock: update the model on the rising edge, return at the falling edge.
    task automatic tick();
        @(posedge CLK);
        if (rst_n && we && add_d != 5'd0) mem[add_d] = wd;
        @(negedge CLK);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    endtask

    initial begin
        rst_n = 1'b0; we = 1'b0; add_a = 5'd0; add_b = 5'd0; add_d = 5'd0; wd = 32'h0;
        model_clear();

        vecs[0]  = '{1'b1, 5'd1, 5'd1, 5'd2, 32'h00000001, 32'h00000001, 32'h0, 32'h0, 32'h0};
        vecs[1]  = '{1'b1, 5'd2, 5'd1, 5'd2, 32'h00000002, 32'h00000001, 32'h00000002, 32'h00000001, 32'h0};
        vecs[2]  = '{1'b0, 5'd0, 5'd1, 5'd2, 32'h0, 32'h00000001, 32'h00000002, 32'h00000001, 32'h00000002};
        vecs[3]  = '{1'b1, 5'd0, 5'd0, 5'd0, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 32'h0};
        vecs[4]  = '{1'b0, 5'd0, 5'd0, 5'd1, 32'h0, 32'h0, 32'h00000001, 32'h0, 32'h00000001};
        vecs[5]  = '{1'b1, 5'd5, 5'd5, 5'd5, 32'h11111111, 32'h11111111, 32'h11111111, 32'h0, 32'h0};
        vecs[6]  = '{1'b1, 5'd5, 5'd5, 5'd5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h11111111, 32'h11111111};
        vecs[7]  = '{1'b0, 5'd5, 5'd5, 5'd5, 32'h0, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5};
        vecs[8]  = '{1'b1, 5'd3, 5'd3, 5'd0, 32'h00000003, 32'h00000003, 32'h0, 32'h0, 32'h0};
        vecs[9]  = '{1'b0, 5'd3, 5'd3, 5'd3, 32'hFFFFFFFF, 32'h00000003, 32'h00000003, 32'h00000003, 32'h00000003};
        vecs[10] = '{1'b0, 5'd3, 5'd3, 5'd3, 32'hFFFFFFFF, 32'h00000003, 32'h00000003, 32'h00000003, 32'h00000003};
        vecs[11] = '{1'b0, 5'd3, 5'd3, 5'd3, 32'hFFFFFFFF, 32'h00000003, 32'h00000003, 32'h00000003, 32'h00000003};
        vecs[12] = '{1'b0, 5'd0, 5'd3, 5'd5, 32'h0, 32'h00000003, 32'hA5A5A5A5, 32'h00000003, 32'hA5A5A5A5};

        @(negedge CLK); @(negedge CLK);
        add_a = 5'd4; add_b = 5'd9; we = 1'b1; add_d = 5'd4; wd = 32'h12345678;
        #1;
        check("reset_hold_a_byp", bus1.REG_A, 32'h0);
        check("reset_hold_b_nobyp", bus0.REG_B, 32'h0);
        @(negedge CLK);
        we = 1'b0;
        check("reset_we_ignored", bus0.REG_A, 32'h0);
        rst_n = 1'b1;

        // Directed table: pre-edge outputs of both instances, then clock.
        for (int v = 0; v < 13; v++) begin
            we = vecs[v].we; add_d = vecs[v].ad; add_a = vecs[v].aa;
            add_b = vecs[v].ab; wd = vecs[v].wd;
            #1;
            check($sformatf("vec%0d_a_byp", v),   bus1.REG_A, vecs[v].ea1);
            check($sformatf("vec%0d_b_byp", v),   bus1.REG_B, vecs[v].eb1);
            check($sformatf("vec%0d_a_nobyp", v), bus0.REG_A, vecs[v].ea0);
            check($sformatf("vec%0d_b_nobyp", v), bus0.REG_B, vecs[v].eb0);
            tick();
        end

        // Asynchronous reset mid-cycle, swept within one half period.
        we = 1'b1; add_d = 5'd7; wd = 32'hCAFEF00D;
        #0.3;
        rst_n = 1'b0;
        model_clear();
        for (int i = 0; i < 32; i++) begin
            add_a = i[4:0]; add_b = 5'd31 - i[4:0];
            #0.1;
            check($sformatf("rst_sweep%0d_a", i), bus1.REG_A, 32'h0);
            check($sformatf("rst_sweep%0d_b", i), bus0.REG_B, 32'h0);
        end
        @(negedge CLK);
        we = 1'b0;
        rst_n = 1'b1;

        // Fill every register, then read all back on both ports.
        for (int i = 1; i < 32; i++) begin
            we = 1'b1; add_d = i[4:0]; wd = i * 32'h01010101;
            tick();
        end
        we = 1'b0;
        for (int i = 1; i < 32; i++) begin
            add_a = i[4:0]; add_b = i[4:0];
            #1;
            check($sformatf("sweep%0d_a", i), bus1.REG_A, i * 32'h01010101);
            check($sformatf("sweep%0d_b", i), bus0.REG_B, i * 32'h01010101);
        end

        // Reset pulse between edges clears everything immediately.
        @(negedge CLK);
        #0.5;
        rst_n = 1'b0;
        model_clear();
        for (int i = 1; i < 32; i += 5) begin
            add_a = i[4:0]; add_b = i[4:0];
            #0.1;
            check($sformatf("rst_pulse%0d", i), bus1.REG_A, 32'h0);
        end
        #0.5;
        rst_n = 1'b1;
        #0.2;
        add_a = 5'd31;
        #0.1;
        check("post_rst_cleared", bus0.REG_A, 32'h0);
        @(negedge CLK);

        // Random traffic against the reference model.
        for (int c = 0; c < 600; c++) begin
            we    = ($urandom_range(0, 3) != 0);
            add_d = 5'($urandom_range(0, 31));
            add_a = ($urandom_range(0, 3) == 0) ? add_d : 5'($urandom_range(0, 31));
            add_b = ($urandom_range(0, 3) == 0) ? add_d : 5'($urandom_range(0, 31));
            wd    = $urandom;
            #1;
            check_model($sformatf("rnd%0d", c));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/riscv_reg_file.md
Name: riscv_reg_file

Overview:
- 32-entry general-purpose register file for the RISC-V integer datapath.
- Two read ports feed the ALU operands (rs1 on port A, rs2 on port B); one synchronous write port serves writeback (rd on port D).
- Register x0 is hardwired to zero.
- Sits between decode (addresses) and execute/writeback (data).

Parameters:
- DATA_W, 32, width of each register and of all data ports.
- ADDR_W, 5, register address width; depth = 2**ADDR_W.
- BYPASS, 1, 1 = a same-cycle write to a read address is forwarded to that read port; 0 = read port shows the stored value.

Ports:
- CLK  in  1  clock; all writes occur on the rising edge.
- RST_N  in  1  asynchronous active-low reset; clears every register.
- ADD_A  in  ADDR_W  read port A address (rs1).
- ADD_B  in  ADDR_W  read port B address (rs2).
- ADD_D  in  ADDR_W  write address (rd).
- REG_D  in  DATA_W  write data.
- WE  in  1  write enable, active high.
- REG_A  out  DATA_W  read data, port A.
- REG_B  out  DATA_W  read data, port B.

Behaviour:
- Storage: 2**ADDR_W registers of DATA_W bits. Entry 0 exists logically but is always read as zero.
- Reset:
  - RST_N low clears all registers to 0 immediately, with no clock required.
  - REG_A and REG_B therefore read 0 while reset is held.
  - WE is ignored while RST_N is low.
  - Deassertion takes effect on the next rising edge.
- Write:
  - On a CLK rising edge with RST_N high, WE=1 and ADD_D!=0, the register at ADD_D takes REG_D.
  - WE=0 leaves all registers unchanged.
  - Writes to address 0 are discarded.
- Read:
  - Combinational, zero latency.
  - REG_A = reg[ADD_A] and REG_B = reg[ADD_B].
  - Each output updates within the same cycle when its address or the stored contents change.
- x0 rule: if ADD_A==0, REG_A=0 unconditionally (including during bypass); the same applies to port B.
- Bypass, BYPASS=1:
  - If WE=1, ADD_D!=0 and ADD_A==ADD_D, then REG_A=REG_D combinationally, before the edge. Port B behaves the same.
  - After the edge, the stored value equals the forwarded value, so no glitch in the architectural value.
- Bypass, BYPASS=0: reads return the pre-edge stored value until the write edge, then the new value.
- Simultaneous events:
  - A and B may address the same register; both return identical data.
  - A write and two reads may all hit the same address in one cycle; the bypass rule applies to both ports.
- Reset mid-operation: a write pending on the same edge as RST_N assertion is lost; the register is 0.
- No X propagation from unused state: every entry is defined after the first reset.
- Width rules: data passes through unmodified; no sign or zero extension. Addresses wider than ADDR_W are not supported; inputs are exactly ADDR_W bits.

Test Plan:
- Reset check: assert RST_N=0 asynchronously mid-cycle, sweep ADD_A/ADD_B over 0..31 -> REG_A=REG_B=0 for every address, with no clock edge required.
- Basic write/read:
  - WE=1, ADD_D=1, REG_D=32'h1 on edge 1; then ADD_D=2, REG_D=32'h2 on edge 2.
  - Then ADD_A=1, ADD_B=2 -> REG_A=32'h1, REG_B=32'h2.
- x0 hardwire: WE=1, ADD_D=0, REG_D=32'hDEADBEEF, clock; ADD_A=0 -> REG_A=0. Also with same-cycle bypass active -> REG_A=0.
- Bypass (BYPASS=1):
  - x5 holds 32'h11111111. Drive WE=1, ADD_D=5, REG_D=32'hA5A5A5A5, ADD_A=ADD_B=5.
  - Before the edge -> REG_A=REG_B=32'hA5A5A5A5; after the edge the value is unchanged.
  - With BYPASS=0 -> 32'h11111111 before the edge, 32'hA5A5A5A5 after.
- Write-enable gating: x3=32'h3; drive WE=0, ADD_D=3, REG_D=32'hFFFFFFFF for 3 edges -> REG_A (ADD_A=3) stays 32'h3.
- Full sweep plus reset mid-run:
  - Write reg[i]=i*32'h01010101 for i=1..31; read back all 31 on both ports -> values match.
  - Pulse RST_N low between edges -> all reads 0 immediately.
